// File: rtl/hex_scan_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Up to eight digits are supported; the leading-zero helper works on the widest case.
package hex_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         MAX_DIGITS = 8;

    // Bit k set means digit k and every digit to its left hold zero; digit 0 is never set.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] shadow,
                                                      input int num_digits);
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
            if (k < num_digits) begin
                zero_above = zero_above & (shadow[4*k +: 4] == 4'h0);
                lz_mask[k] = zero_above;
            end
        end
    endfunction

endpackage

// File: rtl/HexDriver.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
// Purely combinational; the scan controller owns the only instance.
module HexDriver (
    input  logic [3:0] In0,
    output logic [6:0] Out0
);

    always_comb begin
        unique case (In0)
            4'h0: Out0 = 7'h40;
            4'h1: Out0 = 7'h79;
            4'h2: Out0 = 7'h24;
            4'h3: Out0 = 7'h30;
            4'h4: Out0 = 7'h19;
            4'h5: Out0 = 7'h12;
            4'h6: Out0 = 7'h02;
            4'h7: Out0 = 7'h78;
            4'h8: Out0 = 7'h00;
            4'h9: Out0 = 7'h10;
            4'hA: Out0 = 7'h08;
            4'hB: Out0 = 7'h03;
            4'hC: Out0 = 7'h46;
            4'hD: Out0 = 7'h21;
            4'hE: Out0 = 7'h06;
            default: Out0 = 7'h0E;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared HexDriver.
// Value is latched into a shadow only at frame boundaries (or while idle) so a frame never tears.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Enable,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic                    Load_req,
    output logic                    Load_ack,
    input  logic                    Lz_blank,
    output logic [6:0]              Seg_n,
    output logic [NUM_DIGITS-1:0]   Dig_n,
    output logic                    Frame_done
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] CNT_LAST       = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_DIGITS - 1);

    scan_state_t             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q;

    logic [3:0]              nibble;
    logic [6:0]              hex_seg;
    logic [4*MAX_DIGITS-1:0] shadow_ext;
    logic [MAX_DIGITS-1:0]   blank_mask;
    logic                    digit_blanked;

    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   dig_d;
    logic                    frame_d;
    logic                    capture;

    assign nibble = shadow_q[idx_q*4 +: 4];

    HexDriver u_hex (
        .In0  (nibble),
        .Out0 (hex_seg)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!Enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_BLANK_LAST) state_d = DRIVE;
                end
                DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Dropping Enable darkens the pins on the very next edge, not one cycle later.
    always_comb begin
        shadow_ext                     = '0;
        shadow_ext[4*NUM_DIGITS-1:0]   = shadow_q;
        blank_mask                     = lz_mask(shadow_ext, NUM_DIGITS);
        digit_blanked                  = Lz_blank && blank_mask[3'(idx_q)];
        seg_d                          = SEG_BLANK;
        dig_d                          = '1;
        frame_d                        = 1'b0;
        if (Enable && state_q == DRIVE) begin
            dig_d[idx_q] = 1'b0;
            seg_d        = digit_blanked ? SEG_BLANK : hex_seg;
            frame_d      = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
        end
    end

    // Frame_done is high in the last displayed cycle, so its closing edge is the frame boundary.
    assign capture = Load_req && (state_q == IDLE || Frame_done);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Seg_n      <= SEG_BLANK;
            Dig_n      <= '1;
            Frame_done <= 1'b0;
            Load_ack   <= 1'b0;
            shadow_q   <= '0;
        end else begin
            Seg_n      <= seg_d;
            Dig_n      <= dig_d;
            Frame_done <= frame_d;
            Load_ack   <= capture;
            if (capture) shadow_q <= Value;
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
// Expected pin values come from a slot-position model of the scan and a constant segment table.
module tb_hex_scan_ctrl;

    localparam int ND = 4;
    localparam int PS = 8;
    localparam int BC = 2;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Enable;
    logic [15:0] Value;
    logic        Load_req;
    logic        Load_ack;
    logic        Lz_blank;
    logic [6:0]  Seg_n;
    logic [3:0]  Dig_n;
    logic        Frame_done;

    int vectors     = 0;
    int miscompares = 0;

    // {Load_ack, Frame_done, Dig_n, Seg_n}
    logic [12:0] exp_q[$];

    always #5 Clk = ~Clk;

    hex_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Enable     (Enable),
        .Value      (Value),
        .Load_req   (Load_req),
        .Load_ack   (Load_ack),
        .Lz_blank   (Lz_blank),
        .Seg_n      (Seg_n),
        .Dig_n      (Dig_n),
        .Frame_done (Frame_done)
    );

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Pins seen after the n-th edge since Enable rose in IDLE: {Frame_done, Dig_n, Seg_n}.
    function automatic logic [11:0] scan_model(input int n, input logic [15:0] sh, input logic lz);
        int p, slot, cnt;
        logic [3:0] dig;
        logic [6:0] seg;
        if (n < 2) return {1'b0, 4'hF, 7'h7F};
        p    = n - 2;
        slot = (p / PS) % ND;
        cnt  = p % PS;
        if (cnt < BC) return {1'b0, 4'hF, 7'h7F};
        dig       = 4'hF;
        dig[slot] = 1'b0;
        seg       = hex7(sh[slot*4 +: 4]);
        if (lz && slot > 0 && (sh >> (4*slot)) == 16'h0) seg = 7'h7F;
        return {(slot == ND-1 && cnt == PS-1), dig, seg};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s observed=no_expected_entry expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'({Load_ack, Frame_done, Dig_n, Seg_n}), 32'(e));
        end
    endtask

    task automatic apply_reset();
        Reset_n  = 1'b0;
        Enable   = 1'b0;
        Load_req = 1'b0;
        Lz_blank = 1'b0;
        Value    = 16'h0;
        tick();
        tick();
        Reset_n = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 4'hF, 7'h7F});
        check_out("reset_state");
    endtask

    task automatic load_idle(input logic [15:0] v);
        Value    = v;
        Load_req = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 4'hF, 7'h7F});
        tick();
        check_out("idle_load_ack");
        Load_req = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 4'hF, 7'h7F});
        tick();
        check_out("idle_ack_single");
    endtask

    // Scan from IDLE for `cycles` edges; a request raised after sample req_n is acked after edge ack_n.
    task automatic run_scan(input string tag, input int cycles, input logic [15:0] sh0,
                            input logic [15:0] sh1, input int ack_n, input int req_n, input logic lz);
        Enable   = 1'b1;
        Lz_blank = lz;
        for (int n = 1; n <= cycles; n++) begin
            exp_q.push_back({(n == ack_n),
                             scan_model(n, (ack_n > 0 && n > ack_n) ? sh1 : sh0, lz)});
            tick();
            check_out(tag);
            if (Load_ack) Load_req = 1'b0;
            if (n == req_n) Load_req = 1'b1;
        end
    endtask

    initial begin
        int acks;
        Reset_n  = 1'b0;
        Enable   = 1'b0;
        Load_req = 1'b0;
        Lz_blank = 1'b0;
        Value    = 16'h0;

        // Plain scan of an all-zero shadow, two full frames.
        apply_reset();
        run_scan("t1_scan", 70, 16'h0, 16'h0, 0, 0, 1'b0);

        // Mid-frame request waits for the frame boundary.
        apply_reset();
        Value = 16'h12AF;
        run_scan("t2_load", 70, 16'h0, 16'h12AF, 34, 10, 1'b0);

        // Leading-zero blanking.
        apply_reset();
        load_idle(16'h0030);
        run_scan("t3_lz", 36, 16'h0030, 16'h0030, 0, 0, 1'b1);
        Enable = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 4'hF, 7'h7F});
        tick();
        check_out("t3_disable_dark");
        load_idle(16'h0000);
        run_scan("t3_zero", 36, 16'h0, 16'h0, 0, 0, 1'b1);

        // Load while idle, display stays dark until enabled.
        apply_reset();
        load_idle(16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 1'b0, 4'hF, 7'h7F});
            tick();
            check_out("t4_idle_dark");
        end
        run_scan("t4_beef", 36, 16'hBEEF, 16'hBEEF, 0, 0, 1'b0);

        // Request held across three frame ends.
        apply_reset();
        Value  = 16'h1234;
        Enable = 1'b1;
        acks   = 0;
        for (int n = 1; n <= 100; n++) begin
            exp_q.push_back({(n == 34 || n == 66 || n == 98),
                             scan_model(n, (n > 34) ? 16'h1234 : 16'h0, 1'b0)});
            tick();
            check_out("t5_held");
            if (Load_ack) acks++;
            if (n == 1) Load_req = 1'b1;
            if (n == 98) Load_req = 1'b0;
        end
        check("t5_ack_count", 32'(acks), 32'd3);

        // Reset mid-DRIVE with a request pending.
        apply_reset();
        Value = 16'h5A5A;
        run_scan("t6_pre", 20, 16'h0, 16'h5A5A, 0, 10, 1'b0);
        Reset_n = 1'b0;
        #1;
        exp_q.push_back({1'b0, 1'b0, 4'hF, 7'h7F});
        check_out("t6_async_dark");
        Load_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b0, 1'b0, 4'hF, 7'h7F});
            tick();
            check_out("t6_in_reset");
        end
        Reset_n = 1'b1;
        run_scan("t6_post", 40, 16'h0, 16'h0, 0, 0, 1'b0);

        // Enable falls in the Frame_done cycle while a load is pending.
        apply_reset();
        Value = 16'h0C00;
        run_scan("t7_pre", 33, 16'h0, 16'h0C00, 0, 10, 1'b0);
        Enable = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 4'hF, 7'h7F});
        tick();
        check_out("t7_ack_on_disable");
        Load_req = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 4'hF, 7'h7F});
        tick();
        check_out("t7_dark");
        run_scan("t7_resume", 36, 16'h0C00, 16'h0C00, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
